// File: rtl/print_sprite.sv
// Per-pixel sprite hit test: compares the beam against a movable sprite box and emits memory address/select/enable.
// Latency: one cycle from p_x/p_y/active to address/element/enable (all registered).
// Backpressure: none; a new beam pixel is accepted every clock and results stream out unconditionally.
module print_sprite #(
    parameter int initialPosition_x   = 50,
    parameter int initialPosition_y   = 300,
    parameter int amountMemoryElement = 4,
    parameter int memoryElement       = 1,
    parameter int addr_width          = 10,
    parameter int width_x             = 6,
    parameter int width_y             = 6,
    parameter int sizeSprite_x        = 25,
    parameter int sizeSprite_y        = 25
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10:0]                    p_x,
    input  logic [9:0]                     p_y,
    input  logic                           active,
    input  logic [width_x-1:0]             offset_x,
    input  logic [width_y-1:0]             offset_y,
    input  logic [10:0]                    new_position_x,
    input  logic [9:0]                     new_position_y,
    input  logic                           moveSprite,
    output logic [addr_width-1:0]          address,
    output logic [amountMemoryElement-1:0] element,
    output logic                           enable
);

    // Wide enough for (row+offset)*stride + column+offset without overflow
    // before the final truncation to the memory address width.
    localparam int PROD_W = 32;

    localparam logic [amountMemoryElement-1:0] ELEM_ONE =
        {{(amountMemoryElement-1){1'b0}}, 1'b1};
    localparam logic [amountMemoryElement-1:0] ELEM_HOT = ELEM_ONE << memoryElement;

    logic [10:0] pos_x;
    logic [9:0]  pos_y;

    // Box edges are one bit wider than the coordinates so a sprite that
    // hangs past the screen edge is clipped rather than wrapping to 0.
    logic [11:0] end_x;
    logic [10:0] end_y;
    logic        hit;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic [11:0] lx;
    logic [10:0] ly;
    logic [PROD_W-1:0] addr_full;

    // Hit test and local address, evaluated against the position held before this edge.
    always_comb begin
        end_x     = {1'b0, pos_x} + 12'(sizeSprite_x);
        end_y     = {1'b0, pos_y} + 11'(sizeSprite_y);
        hit       = active
                  && (p_x >= pos_x) && ({1'b0, p_x} < end_x)
                  && (p_y >= pos_y) && ({1'b0, p_y} < end_y);
        dx        = p_x - pos_x;
        dy        = p_y - pos_y;
        lx        = {1'b0, dx} + 12'(offset_x);
        ly        = {1'b0, dy} + 11'(offset_y);
        addr_full = PROD_W'(ly) * PROD_W'(sizeSprite_x) + PROD_W'(lx);
    end

    // Sprite position register: reset to the start corner, reloaded every cycle moveSprite is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_x <= 11'(initialPosition_x);
            pos_y <= 10'(initialPosition_y);
        end else if (moveSprite) begin
            pos_x <= new_position_x;
            pos_y <= new_position_y;
        end
    end

    // Registered pixel-mux controls; everything is cleared on a miss or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            address <= '0;
            element <= '0;
            enable  <= 1'b0;
        end else if (hit) begin
            address <= addr_full[addr_width-1:0];
            element <= ELEM_HOT;
            enable  <= 1'b1;
        end else begin
            address <= '0;
            element <= '0;
            enable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_print_sprite.sv
// Scoreboard bench for print_sprite: directed pixels, expected outputs queued per cycle.
// Latency: expectations are due one clock after the inputs are driven.
// Backpressure: none; the monitor compares every cycle that has a queued expectation.
module tb_print_sprite;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] p_x;
    logic [9:0]  p_y;
    logic        active;
    logic [5:0]  offset_x;
    logic [5:0]  offset_y;
    logic [10:0] new_position_x;
    logic [9:0]  new_position_y;
    logic        moveSprite;
    logic [9:0]  address;
    logic [3:0]  element;
    logic        enable;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        string       name;
        logic        en;
        logic [3:0]  el;
        logic [9:0]  addr;
    } exp_t;

    exp_t sb[$];

    print_sprite dut (
        .clk            (clk),
        .reset          (reset),
        .p_x            (p_x),
        .p_y            (p_y),
        .active         (active),
        .offset_x       (offset_x),
        .offset_y       (offset_y),
        .new_position_x (new_position_x),
        .new_position_y (new_position_y),
        .moveSprite     (moveSprite),
        .address        (address),
        .element        (element),
        .enable         (enable)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the hand-computed result.
    task automatic step(input string name, input logic rst, input logic act,
                        input int px, input int py, input int ox, input int oy,
                        input logic mv, input int nx, input int ny,
                        input logic e_en, input logic [3:0] e_el, input int e_addr);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        active         = act;
        p_x            = 11'(px);
        p_y            = 10'(py);
        offset_x       = 6'(ox);
        offset_y       = 6'(oy);
        moveSprite     = mv;
        new_position_x = 11'(nx);
        new_position_y = 10'(ny);
        e.due  = cyc + 1;
        e.name = name;
        e.en   = e_en;
        e.el   = e_el;
        e.addr = 10'(e_addr);
        sb.push_back(e);
    endtask

    // Monitor: away from the active edge, pop and compare whatever is due now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (enable !== e.en) begin
                    n_fail++;
                    $display("FAIL %s enable: got %b want %b", e.name, enable, e.en);
                end
                n_checks++;
                if (element !== e.el) begin
                    n_fail++;
                    $display("FAIL %s element: got %b want %b", e.name, element, e.el);
                end
                n_checks++;
                if (address !== e.addr) begin
                    n_fail++;
                    $display("FAIL %s address: got %0d want %0d", e.name, address, e.addr);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; active = 1'b0; p_x = '0; p_y = '0;
        offset_x = '0; offset_y = '0; moveSprite = 1'b0;
        new_position_x = '0; new_position_y = '0;

        //    name          rst act  px    py   ox oy mv  nx    ny    en  el       addr
        step("reset0",      0,  1,  50,  300,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("reset1",      0,  1,  50,  300,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("corner",      1,  1,  50,  300,  0, 0, 0,  0,    0,   1, 4'b0010, 0);
        step("far_corner",  1,  1,  74,  324,  0, 0, 0,  0,    0,   1, 4'b0010, 624);
        step("right_edge",  1,  1,  75,  300,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("bottom_edge", 1,  1,  50,  325,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("left_edge",   1,  1,  49,  300,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("top_edge",    1,  1,  50,  299,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("inactive",    1,  0,  60,  310,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("interior",    1,  1,  60,  310,  0, 0, 0,  0,    0,   1, 4'b0010, 260);
        // Move while hitting: this cycle still uses the old position.
        step("move_oldpos", 1,  1,  50,  300,  0, 0, 1,  50,   299, 1, 4'b0010, 0);
        step("moved_top",   1,  1,  50,  299,  0, 0, 0,  0,    0,   1, 4'b0010, 0);
        step("moved_bot",   1,  1,  50,  324,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("moved_last",  1,  1,  50,  323,  0, 0, 0,  0,    0,   1, 4'b0010, 600);
        // Reset during a hit clears outputs at that edge and restores position.
        step("rst_hit",     0,  1,  50,  300,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("rst_pos_top", 1,  1,  50,  299,  0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("rst_pos_bot", 1,  1,  50,  324,  0, 0, 0,  0,    0,   1, 4'b0010, 600);
        step("offset",      1,  1,  50,  300,  3, 1, 0,  0,    0,   1, 4'b0010, 28);
        step("offset_far",  1,  1,  74,  324,  3, 1, 0,  0,    0,   1, 4'b0010, 652);
        step("addr_wrap",   1,  1,  74,  324, 63,63, 0,  0,    0,   1, 4'b0010, 214);
        step("rst_midfrm",  0,  1,  50,  300,  3, 1, 0,  0,    0,   0, 4'b0000, 0);
        // Sprite hanging past the bottom-right screen corner is clipped, not wrapped.
        step("move_edge",   1,  0,  0,   0,    0, 0, 1,  2040, 1020, 0, 4'b0000, 0);
        step("clip_in",     1,  1,  2047, 1023, 0, 0, 0,  0,    0,   1, 4'b0010, 82);
        step("clip_left",   1,  1,  2039, 1020, 0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("clip_nowrap", 1,  1,  0,   1020, 0, 0, 0,  0,    0,   0, 4'b0000, 0);
        step("clip_nowrapy",1,  1,  2040, 0,   0, 0, 0,  0,    0,   0, 4'b0000, 0);

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
